// File: rtl/mips_mem_ctrl.sv
// Wait-state memory controller for a MIPS-style core: one request at a time, IDLE -> WAIT -> RESP.
// Define MEM_MISALIGN_ERR_EN to flag accesses with addr[1:0] != 0 via err and suppress their effect.
module mips_mem_ctrl #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            capture;
    logic            access;
    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic            mis_q;
    logic            addr_unused;

    logic [31:0] mem [DEPTH];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    cnt_d   = WAIT_LD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata   <= 32'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
`ifdef MEM_MISALIGN_ERR_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                we_q    <= we;
                idx_q   <= addr[AW+1:2];
                wdata_q <= wdata;
`ifdef MEM_MISALIGN_ERR_EN
                mis_q   <= |addr[1:0];
`endif
            end
            if (access && !we_q) begin
                rdata <= mis_q ? 32'd0 : mem[idx_q];
            end
        end
    end

    // NOTE: storage has no reset; the write enable is gated by state, which reset forces to IDLE.
    always_ff @(posedge clk) begin
        if (access && we_q && !mis_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

`ifdef MEM_MISALIGN_ERR_EN
    assign addr_unused = ^addr[31:AW+2];
`else
    assign mis_q       = 1'b0;
    assign addr_unused = ^{addr[31:AW+2], addr[1:0]};
`endif

    assign ready = (state_q == RESP);
    assign busy  = (state_q != IDLE);
    assign err   = ready && mis_q;

endmodule

// File: tb/tb_mips_mem_ctrl.sv
// Directed self-checking bench for mips_mem_ctrl at default parameters (DEPTH=256, WAIT_CYCLES=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mips_mem_ctrl;

    localparam int LAT = 4;  // falling edges from drive to ready with WAIT_CYCLES = 2

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    mips_mem_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .busy  (busy),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE, scramble the inputs once it is captured, and return
    // on the falling edge where ready is seen (or when the cycle budget runs out).
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
        int   lat;
        logic busy_ok;
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = ~w; addr = ~a; wdata = ~d;
        lat     = 1;
        busy_ok = busy;
        while (ready !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            busy_ok = busy_ok & busy;
        end
        check({tag, " latency"}, lat, LAT);
        check({tag, " busy"}, busy_ok, 1'b1);
    endtask

    initial begin
        int n_rdy;
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;

        #23;
        check("rst rdata", rdata, 32'd0);
        check("rst ready", ready, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst err", err, 1'b0);
        #527;
        rst = 1'b1;
        #1;
        @(negedge clk);

        // Write then read back word 4.
        xact(1'b1, 32'h10, 32'hDEADBEEF, "wr10");
        check("wr10 err", err, 1'b0);
        @(negedge clk);
        check("wr10 ready drop", ready, 1'b0);
        check("wr10 busy drop", busy, 1'b0);
        xact(1'b0, 32'h10, 32'h0, "rd10");
        check("rd10 rdata", rdata, 32'hDEADBEEF);
        @(negedge clk);

        // Address wrap: 0x400 aliases word 0; the write leaves rdata unchanged.
        xact(1'b1, 32'h400, 32'h12345678, "wr400");
        check("wr400 rdata hold", rdata, 32'hDEADBEEF);
        @(negedge clk);
        xact(1'b0, 32'h0, 32'h0, "rd0");
        check("rd0 wrap rdata", rdata, 32'h12345678);
        @(negedge clk);

        xact(1'b1, 32'h20, 32'hA0A0A0A0, "wr20");
        @(negedge clk);
        xact(1'b1, 32'h24, 32'hB1B1B1B1, "wr24");
        @(negedge clk);

        // req held high: captures on edges 0, 5, 10 -> ready seen at c = 4, 9, 14.
        req = 1'b1; we = 1'b0; addr = 32'h20; wdata = 32'h0BAD0BAD;
        n_rdy = 0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (ready === 1'b1) n_rdy++;
            if (c == 4) begin
                check("b2b ready 1", ready, 1'b1);
                check("b2b rdata 1", rdata, 32'hA0A0A0A0);
            end
            if (c == 9) begin
                check("b2b ready 2", ready, 1'b1);
                check("b2b rdata 2", rdata, 32'hB1B1B1B1);
            end
            if (c == 14) begin
                check("b2b ready 3", ready, 1'b1);
                check("b2b rdata 3", rdata, 32'hDEADBEEF);
            end
            case (c)
                1:  begin addr = 32'h0;   we = 1'b1; end
                5:  begin addr = 32'h24;  we = 1'b0; end
                6:  begin addr = 32'h400; we = 1'b1; end
                10: begin addr = 32'h10;  we = 1'b0; end
                11: begin addr = 32'h20;  req = 1'b0; end
                default: ;
            endcase
        end
        check("b2b pulses", n_rdy, 3);

        // Reset in WAIT aborts the pending write to word 8.
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h5555AAAA;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort rdata", rdata, 32'd0);
        check("abort ready", ready, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort err", err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        xact(1'b0, 32'h20, 32'h0, "rd20 after abort");
        check("rd20 after abort rdata", rdata, 32'hA0A0A0A0);
        @(negedge clk);

        // Misaligned write to 0x13 (word 4).
        xact(1'b1, 32'h13, 32'hCAFEF00D, "wr13");
`ifdef MEM_MISALIGN_ERR_EN
        check("wr13 err", err, 1'b1);
`else
        check("wr13 err", err, 1'b0);
`endif
        check("wr13 rdata hold", rdata, 32'hA0A0A0A0);
        @(negedge clk);
        check("wr13 err drop", err, 1'b0);
        xact(1'b0, 32'h10, 32'h0, "rd10 after wr13");
`ifdef MEM_MISALIGN_ERR_EN
        check("rd10 after wr13 rdata", rdata, 32'hDEADBEEF);
        @(negedge clk);
        xact(1'b0, 32'h11, 32'h0, "rd11");
        check("rd11 err", err, 1'b1);
        check("rd11 rdata", rdata, 32'd0);
`else
        check("rd10 after wr13 rdata", rdata, 32'hCAFEF00D);
        check("rd10 err", err, 1'b0);
`endif
        @(negedge clk);
        check("final idle busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
